video_timing_gen: RTL
=====================

# video_timing_gen

Raster timing generator for the HDMI output path. It produces hs/vs/de and pixel data for one fixed video mode (default 1080p60) and drives a pixel read-request interface (rd_en, rd_x, rd_y) toward the frame-buffer reader. Returned pixel data is aligned with the generated timing. It sits upstream of the HDMI encoder and of any block that recovers x/y position from hs/vs/de.

## Interface
- DATA_WIDTH, 24, pixel width
- H_ACTIVE / H_FP / H_SYNC / H_BP, 1920 / 88 / 44 / 148, horizontal active, front porch, sync, back porch (pixels)
- V_ACTIVE / V_FP / V_SYNC / V_BP, 1080 / 4 / 5 / 36, vertical equivalents (lines)
- HS_POL / VS_POL, 1 / 1, sync polarity (1 = active-high)
- DATA_LATENCY, 2, cycles from rd_en to valid i_data (range 0..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- i_data  in  DATA_WIDTH  pixel returned by the reader
- rd_en  out  1  pixel request
- rd_x  out  12  requested column
- rd_y  out  12  requested line
- frame_start  out  1  one-cycle pulse at the first request slot of a frame
- o_hs  out  1  horizontal sync
- o_vs  out  1  vertical sync
- o_de  out  1  data enable
- o_data  out  DATA_WIDTH  pixel, zero outside de

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4096. All counters are 12 bits.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h_cnt wrap and wraps from V_TOTAL-1 to 0.
- Region order in each dimension: active, then front porch, then sync, then back porch.
  - Active: cnt < ACTIVE.
  - Sync: ACTIVE+FP ≤ cnt < ACTIVE+FP+SYNC.
- Stage-0 decode, registered:
  - rd_en = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - rd_x = h_cnt when rd_en, else 0.
  - rd_y = v_cnt when v_cnt < V_ACTIVE, else 0.
  - frame_start = (h_cnt == 0 && v_cnt == 0).
- hs and vs are decoded from the counters in the same stage. vs changes only at h_cnt wrap, i.e. it is line-aligned, not half-line.
- hs, vs and de pass through a DATA_LATENCY-deep shift register, then one output register.
  - o_data <= delayed_de ? i_data : 0.
- en low:
  - h_cnt and v_cnt are forced to 0 each cycle.
  - rd_en and frame_start are forced low.
  - The delay line keeps shifting inactive values, so outputs drain to idle within DATA_LATENCY+1 cycles.
- en rising: counting starts at (0,0). frame_start and the first rd_en occur the cycle after the first en-high cycle.
- en falling mid-frame aborts the frame. The next enable starts a fresh frame at (0,0).

## Timing
- Reset values (rst high at a clock edge takes precedence over en):
  - o_hs = ~HS_POL, o_vs = ~VS_POL.
  - o_de = 0, o_data = 0.
  - rd_en = 0, rd_x = 0, rd_y = 0, frame_start = 0.
  - Counters = 0.
  - Delay line filled with the inactive levels.
- Request latency: counter state in cycle n appears on rd_en/rd_x/rd_y/frame_start in cycle n+1.
- Data contract: the reader presents the pixel for a request issued in cycle t on i_data in cycle t+DATA_LATENCY. i_data is ignored in every other cycle.
- Output latency: o_de/o_hs/o_vs/o_data for that pixel are valid in cycle t+DATA_LATENCY+1.
- Relative alignment of hs, vs and de at the outputs is identical to their alignment at stage 0.
- Counts per frame when continuously enabled:
  - rd_en high for exactly H_ACTIVE consecutive cycles per active line.
  - H_ACTIVE×V_ACTIVE rd_en cycles per frame.
  - Frame period H_TOTAL×V_TOTAL cycles.
- No backpressure: the reader must meet the latency contract every cycle.

## Configuration
- VTG_TEST_PATTERN_EN defined:
  - o_data during de is an internal 8-bar colour pattern; i_data is ignored.
  - Bar width is H_ACTIVE/8, with the remainder absorbed by the last bar. Bar tracking uses a bar counter, not a divider.
  - Colours, left to right, RGB888 (DATA_WIDTH 24): FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - rd_en/rd_x/rd_y/frame_start still behave normally.
- Not defined: o_data follows i_data per the data contract.

## Test plan
Small-mode parameters for all scenarios: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), DATA_LATENCY 2, HS/VS_POL 1.

- Reset check: hold rst 5 cycles with en=1 → all outputs at their reset values; the first frame_start comes 1 cycle after rst falls.
- Request pattern: en=1 with one full frame observed.
  - rd_en high for 8 cycles per line on 4 lines, rd_x 0..7, rd_y 0..3.
  - frame_start period is 98 cycles.
- Latency: reader model returns {rd_y, rd_x} 2 cycles after each request → o_de rises 3 cycles after rd_en, and o_data sequence 0x000..0x007 on the first line.
- Sync placement:
  - o_hs high for 2 cycles, starting 10 cycles after the first o_de of each line.
  - o_vs high for 1 line (14 cycles), starting at line 5.
- Mid-frame stop: drop en at line 2, x=3 for 10 cycles, then raise it.
  - rd_en goes low the next cycle.
  - Outputs idle within 3 cycles.
  - Restart gives frame_start with rd_x=0, rd_y=0.
- With VTG_TEST_PATTERN_EN (H_ACTIVE=16): o_data per line is 2 pixels of each of the 8 bar colours, in order, independent of i_data.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for one fixed video mode.
// Counters -> registered stage-0 decode (pixel requests + hs/vs/de) ->
// DATA_LATENCY-deep timing delay line -> output register merging pixel data.
// Optional feature macro: VTG_TEST_PATTERN_EN replaces i_data with an
// internal 8-bar colour pattern on o_data.
module video_timing_gen #(
  parameter int DATA_WIDTH   = 24,
  parameter int H_ACTIVE     = 1920,
  parameter int H_FP         = 88,
  parameter int H_SYNC       = 44,
  parameter int H_BP         = 148,
  parameter int V_ACTIVE     = 1080,
  parameter int V_FP         = 4,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 36,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1,
  parameter int DATA_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  rd_en,
  output logic [11:0]           rd_x,
  output logic [11:0]           rd_y,
  output logic                  frame_start,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries held at 13 bits so a 4096-wide total still compares cleanly.
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SE   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SS   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SE   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } tim_t;

  localparam tim_t TIM_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

  logic [11:0] h_cnt, v_cnt;
  logic [12:0] h13, v13;
  logic        h_act, v_act, hs_on, vs_on;
  logic        hs0, vs0;
  tim_t        s0, dly_out;
  logic [DATA_WIDTH-1:0] pix;

  // Region decode of the current raster position.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h13   = {1'b0, h_cnt};
    v13   = {1'b0, v_cnt};
    h_act = 1'b0;
    v_act = 1'b0;
    hs_on = 1'b0;
    vs_on = 1'b0;
    if (h13 < H_ACT)                 h_act = 1'b1;
    if (v13 < V_ACT)                 v_act = 1'b1;
    if (h13 >= H_SS && h13 < H_SE)   hs_on = 1'b1;
    if (v13 >= V_SS && v13 < V_SE)   vs_on = 1'b1;
  end

  // Raster counters; held at (0,0) while disabled so every enable starts a fresh frame.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h13 == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v13 == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 0: registered request interface and sync decode.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      rd_en       <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      frame_start <= 1'b0;
      hs0         <= ~HS_POL;
      vs0         <= ~VS_POL;
    end else begin
      rd_en       <= h_act && v_act;
      rd_x        <= (h_act && v_act) ? h_cnt : '0;
      rd_y        <= v_act ? v_cnt : '0;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      hs0         <= hs_on ? HS_POL : ~HS_POL;
      vs0         <= vs_on ? VS_POL : ~VS_POL;
    end
  end

  assign s0 = '{hs: hs0, vs: vs0, de: rd_en};

  // Timing delay line matching the reader's data latency.
  generate
    if (DATA_LATENCY == 0) begin : g_no_dly
      assign dly_out = s0;
    end else begin : g_dly
      tim_t dly [DATA_LATENCY];
      // Shift stage-0 timing toward the output register.
      // NOTE: this small shift register is reset so the outputs start at idle levels.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DATA_LATENCY; i++) dly[i] <= TIM_IDLE;
        end else begin
          dly[0] <= s0;
          for (int i = 1; i < DATA_LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign dly_out = dly[DATA_LATENCY-1];
    end
  endgenerate

`ifdef VTG_TEST_PATTERN_EN
  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  logic [11:0] bar_pix;
  logic [2:0]  bar_idx;
  logic        unused_i_data;

  assign unused_i_data = ^i_data;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // Bar tracker for the pixel now at the output stage; the last bar absorbs the remainder.
  always_ff @(posedge clk) begin
    if (rst || !dly_out.de) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BAR_LAST && bar_idx != 3'd7) begin
      bar_pix <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + 12'd1;
    end
  end

  assign pix = DATA_WIDTH'(bar_rgb(bar_idx));
`else
  assign pix = i_data;
`endif

  // Output register: delayed timing plus pixel data, blanked outside de.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hs   <= ~HS_POL;
      o_vs   <= ~VS_POL;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      o_hs   <= dly_out.hs;
      o_vs   <= dly_out.vs;
      o_de   <= dly_out.de;
      o_data <= dly_out.de ? pix : '0;
    end
  end

endmodule
